// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard tracker: slot layout,
// the bubble value and the hard-wired zero register index.
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    localparam logic [4:0] REG_X0 = 5'd0;
    localparam slot_t      BUBBLE = '0;

endpackage

// File: rtl/hazard_slot.sv
// One shadow pipeline slot: async active-low clear, hold, load-bubble or load.
// Writes to x0 are stored with regwrite cleared so they never forward.
import hazard_pkg::*;

module hazard_slot (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  hold,
    input  logic  load_bubble,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q <= BUBBLE;
        end else if (!hold) begin
            if (load_bubble) begin
                q <= BUBBLE;
            end else begin
                q.valid    <= d.valid;
                q.rd       <= d.rd;
                q.regwrite <= d.regwrite && (d.rd != REG_X0);
                q.memread  <= d.memread;
            end
        end
    end

endmodule

// File: rtl/hazard_track.sv
// Tracks EX/MEM/WB destinations, raises the load-use stall and feeds forwarding.
// Define HAZARD_STATS_EN to add the saturating StallCount_o counter.
import hazard_pkg::*;

module hazard_track (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_Valid_i,
    input  logic [4:0]  ID_RS1_i,
    input  logic [4:0]  ID_RS2_i,
    input  logic [4:0]  ID_Rd_i,
    input  logic        ID_RegWrite_i,
    input  logic        ID_MemRead_i,
    input  logic        Flush_i,
    input  logic        Freeze_i,
    output logic        Stall_o,
    output logic [4:0]  EXMEM_Rd_o,
    output logic        EXMEM_RegWrite_o,
    output logic [4:0]  MEMWB_Rd_o,
    output logic        MEMWB_RegWrite_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] StallCount_o
`endif
);

    // slot_q[0] = EX, slot_q[1] = MEM, slot_q[2] = WB
    slot_t slot_q [3];
    slot_t slot_d [3];
    slot_t id_slot;
    logic  ex_bubble;
    logic  unused_memread;

    assign id_slot.valid    = ID_Valid_i;
    assign id_slot.rd       = ID_Rd_i;
    assign id_slot.regwrite = ID_RegWrite_i;
    assign id_slot.memread  = ID_MemRead_i;

    // A flush overrides the stall but still kills the ID instruction.
    assign Stall_o = slot_q[0].valid && slot_q[0].memread && (slot_q[0].rd != REG_X0)
                     && ID_Valid_i
                     && ((slot_q[0].rd == ID_RS1_i) || (slot_q[0].rd == ID_RS2_i))
                     && !Flush_i;

    assign ex_bubble = Flush_i || Stall_o || !ID_Valid_i;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_slot
            if (gi == 0) begin : g_ex
                assign slot_d[gi] = id_slot;
            end else begin : g_shift
                assign slot_d[gi] = slot_q[gi-1];
            end

            hazard_slot u_slot (
                .clk_i       (clk_i),
                .rst_i       (rst_i),
                .hold        (Freeze_i),
                .load_bubble ((gi == 0) ? ex_bubble : 1'b0),
                .d           (slot_d[gi]),
                .q           (slot_q[gi])
            );
        end
    endgenerate

    assign EXMEM_Rd_o       = slot_q[1].valid ? slot_q[1].rd       : REG_X0;
    assign EXMEM_RegWrite_o = slot_q[1].valid ? slot_q[1].regwrite : 1'b0;
    assign MEMWB_Rd_o       = slot_q[2].valid ? slot_q[2].rd       : REG_X0;
    assign MEMWB_RegWrite_o = slot_q[2].valid ? slot_q[2].regwrite : 1'b0;

    // Load flags only matter in EX; downstream copies are intentionally unused.
    assign unused_memread = slot_q[1].memread ^ slot_q[2].memread;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            StallCount_o <= '0;
        end else if (!Freeze_i && Stall_o && (StallCount_o != 32'hFFFF_FFFF)) begin
            StallCount_o <= StallCount_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_track.sv
// Directed self-checking bench for hazard_track; build with HAZARD_STATS_EN
// defined to also exercise the stall counter.
`timescale 1ns/1ps
module tb_hazard_track;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ID_Valid_i;
    logic [4:0]  ID_RS1_i, ID_RS2_i, ID_Rd_i;
    logic        ID_RegWrite_i, ID_MemRead_i;
    logic        Flush_i, Freeze_i;
    logic        Stall_o;
    logic [4:0]  EXMEM_Rd_o, MEMWB_Rd_o;
    logic        EXMEM_RegWrite_o, MEMWB_RegWrite_o;
`ifdef HAZARD_STATS_EN
    logic [31:0] StallCount_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    hazard_track dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .ID_Valid_i       (ID_Valid_i),
        .ID_RS1_i         (ID_RS1_i),
        .ID_RS2_i         (ID_RS2_i),
        .ID_Rd_i          (ID_Rd_i),
        .ID_RegWrite_i    (ID_RegWrite_i),
        .ID_MemRead_i     (ID_MemRead_i),
        .Flush_i          (Flush_i),
        .Freeze_i         (Freeze_i),
        .Stall_o          (Stall_o),
        .EXMEM_Rd_o       (EXMEM_Rd_o),
        .EXMEM_RegWrite_o (EXMEM_RegWrite_o),
        .MEMWB_Rd_o       (MEMWB_Rd_o),
        .MEMWB_RegWrite_o (MEMWB_RegWrite_o)
`ifdef HAZARD_STATS_EN
        ,
        .StallCount_o     (StallCount_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic check_count(input string tag, input logic [31:0] exp);
`ifdef HAZARD_STATS_EN
        check(tag, StallCount_o, exp);
`else
        if (exp == 32'hDEAD_BEEF) $display("%s", tag);
`endif
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        ID_Valid_i    = v;
        ID_RS1_i      = rs1;
        ID_RS2_i      = rs2;
        ID_Rd_i       = rd;
        ID_RegWrite_i = rw;
        ID_MemRead_i  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    initial begin
        rst_i    = 1'b0;
        Flush_i  = 1'b0;
        Freeze_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (2) tick();
        check("rst_stall", {31'd0, Stall_o}, 32'd0);
        check("rst_exmem_rd", {27'd0, EXMEM_Rd_o}, 32'd0);
        check("rst_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd0);
        check("rst_memwb_rd", {27'd0, MEMWB_Rd_o}, 32'd0);
        check_count("rst_count", 32'd0);
        rst_i = 1'b1;
        tick();

        // Load-use: lw x5 then add x6 = x5 + ...
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        check("lu_no_stall_first", {31'd0, Stall_o}, 32'd0);
        tick();
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);
        check("lu_stall", {31'd0, Stall_o}, 32'd1);
        tick();
        check("lu_stall_one_cycle", {31'd0, Stall_o}, 32'd0);
        check("lu_exmem_rd", {27'd0, EXMEM_Rd_o}, 32'd5);
        check("lu_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd1);
        tick();
        check("lu_memwb_rd", {27'd0, MEMWB_Rd_o}, 32'd5);
        check("lu_memwb_rw", {31'd0, MEMWB_RegWrite_o}, 32'd1);
        check("lu_bubble_in_mem", {27'd0, EXMEM_Rd_o}, 32'd0);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check("lu_add_in_mem", {27'd0, EXMEM_Rd_o}, 32'd6);
        check_count("lu_count", 32'd1);
        drain();

        // ALU producer then consumer on RS2: no stall, forwarded from MEM.
        set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd2, 5'd7, 5'd8, 1'b1, 1'b0);
        check("alu_no_stall", {31'd0, Stall_o}, 32'd0);
        tick();
        check("alu_exmem_rd", {27'd0, EXMEM_Rd_o}, 32'd7);
        check("alu_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd1);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check("alu_memwb_rd", {27'd0, MEMWB_Rd_o}, 32'd7);
        check("alu_consumer_mem", {27'd0, EXMEM_Rd_o}, 32'd8);
        drain();

        // Load into x0: never stalls, never writes.
        set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0);
        check("x0_no_stall", {31'd0, Stall_o}, 32'd0);
        tick();
        check("x0_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd0);
        check_count("x0_count", 32'd1);
        drain();

        // Load-use coinciding with a flush: no stall, bubble in EX.
        set_id(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1);
        tick();
        Flush_i = 1'b1;
        set_id(1'b1, 5'd10, 5'd0, 5'd11, 1'b1, 1'b0);
        check("flush_no_stall", {31'd0, Stall_o}, 32'd0);
        tick();
        Flush_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check("flush_bubble_rw", {31'd0, EXMEM_RegWrite_o}, 32'd0);
        check("flush_bubble_rd", {27'd0, EXMEM_Rd_o}, 32'd0);
        check("flush_load_wb", {27'd0, MEMWB_Rd_o}, 32'd10);
        check_count("flush_count", 32'd1);
        drain();

        // Freeze for 4 cycles with load in EX and dependent in ID.
        set_id(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1);
        tick();
        Freeze_i = 1'b1;
        set_id(1'b1, 5'd1, 5'd12, 5'd13, 1'b1, 1'b0);
        check("frz_stall_start", {31'd0, Stall_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("frz_stall_%0d", i), {31'd0, Stall_o}, 32'd1);
            check($sformatf("frz_exmem_%0d", i), {27'd0, EXMEM_Rd_o}, 32'd11);
            check($sformatf("frz_memwb_%0d", i), {27'd0, MEMWB_Rd_o}, 32'd0);
            check_count($sformatf("frz_count_%0d", i), 32'd1);
        end
        Freeze_i = 1'b0;
        #1;
        tick();
        check("frz_release_stall", {31'd0, Stall_o}, 32'd0);
        check("frz_release_exmem", {27'd0, EXMEM_Rd_o}, 32'd12);
        check("frz_release_memwb", {27'd0, MEMWB_Rd_o}, 32'd11);
        check_count("frz_release_count", 32'd2);
        drain();

        // Async reset mid-cycle with rd=9 in MEM and a stall pending.
        set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b1);
        tick();
        set_id(1'b1, 5'd13, 5'd0, 5'd14, 1'b1, 1'b0);
        check("arst_pre_exmem", {27'd0, EXMEM_Rd_o}, 32'd9);
        check("arst_pre_stall", {31'd0, Stall_o}, 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        check("arst_exmem_rd", {27'd0, EXMEM_Rd_o}, 32'd0);
        check("arst_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd0);
        check("arst_stall", {31'd0, Stall_o}, 32'd0);
        check_count("arst_count", 32'd0);
        #1;
        rst_i = 1'b1;
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        check("resume_exmem_rd", {27'd0, EXMEM_Rd_o}, 32'd14);
        check("resume_exmem_rw", {31'd0, EXMEM_RegWrite_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_track.md
HAZARD_TRACK -- requirements
Module: hazard_track

Interface
REQ-001 SHALL: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: rst_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL: ID_Valid_i  input  1  an instruction is present in the ID stage.
REQ-004 SHALL: ID_RS1_i / ID_RS2_i  input  5 each  source register indices of the ID instruction.
REQ-005 SHALL: ID_Rd_i  input  5  destination register index of the ID instruction.
REQ-006 SHALL: ID_RegWrite_i / ID_MemRead_i  input  1 each  the ID instruction writes Rd / is a load.
REQ-007 SHALL: Flush_i  input  1  kill the ID instruction (taken branch).
REQ-008 SHALL: Freeze_i  input  1  memory busy; holds the whole pipeline.
REQ-009 SHALL: Stall_o  output  1  load-use stall; the PC and IF/ID hold.
REQ-010 SHALL: EXMEM_Rd_o / EXMEM_RegWrite_o  output  5 / 1  MEM-slot destination, feeding forwarding.
REQ-011 SHALL: MEMWB_Rd_o / MEMWB_RegWrite_o  output  5 / 1  WB-slot destination, feeding forwarding.

Function
REQ-012 SHALL: hold three shadow slots EX, MEM and WB; each slot is {valid, rd[4:0], regwrite, memread}.
REQ-013 SHALL: on each edge with Freeze_i=0, shift WB<=MEM and MEM<=EX, and load EX as follows:
- a bubble (all fields 0) if Flush_i, Stall_o or !ID_Valid_i;
- otherwise the ID fields.
REQ-014 SHALL: capture regwrite into a slot only when rd!=0; an x0 write is stored as regwrite=0.
REQ-015 SHALL: assert Stall_o combinationally when all of the following hold:
- EX.valid, EX.memread and EX.rd!=0;
- ID_Valid_i;
- EX.rd equals ID_RS1_i or ID_RS2_i.
REQ-016 SHALL: force Stall_o=0 when Flush_i=1; a flush has priority and still inserts a bubble.
REQ-017 SHALL: bound the stall to exactly 1 cycle per load-use pair, because the bubble clears EX.memread.
REQ-018 SHALL: hold all slots unchanged while Freeze_i=1; Stall_o is still evaluated from the held EX slot.
REQ-019 SHALL: drive EXMEM_* = MEM.valid ? {rd, regwrite} : 0, and MEMWB_* = WB.valid ? {rd, regwrite} : 0.
REQ-020 SHALL: provide zero added latency from slot to output; outputs are registered slot contents gated combinationally.
REQ-021 SHALL: take an instruction from ID acceptance to MEMWB_* visibility in exactly 3 unfrozen edges.

Reset
REQ-022 SHALL: clear all slots to the bubble state immediately on rst_i=0, independent of the clock.
REQ-023 SHALL: hold Stall_o=0 and all EXMEM_*/MEMWB_* outputs at 0 during reset.
REQ-024 SHALL: resume normal shifting on the first edge after rst_i rises.
REQ-025 SHALL: discard any in-flight stall when reset asserts mid-operation.

Configuration
REQ-026 SHALL: with HAZARD_STATS_EN defined, add output StallCount_o[31:0], which:
- increments on every unfrozen edge where Stall_o=1;
- resets to 0;
- saturates at 32'hFFFF_FFFF.
REQ-027 SHALL: without HAZARD_STATS_EN, omit the port and the counter entirely; all other behaviour is identical.

Structure
REQ-028 SHALL: place the slot struct typedef, the bubble constant and the REG_X0 = 5'd0 constant in shared package hazard_pkg.
REQ-029 SHALL: implement each slot as one sub-module instance of hazard_slot, which provides:
- asynchronous active-low clear;
- hold and load-bubble inputs.

Verification
REQ-030 SHALL: lw x5 (Rd=5, MemRead=1), then add with RS1=5:
- Stall_o=1 for exactly 1 cycle;
- EXMEM_Rd_o=5 and EXMEM_RegWrite_o=1 one cycle later;
- MEMWB_Rd_o=5 on the following cycle.
REQ-031 SHALL: an add writing Rd=7, followed by a consumer with RS2=7, gives Stall_o=0 and EXMEM_Rd_o=7 two edges after ID acceptance.
REQ-032 SHALL: a load with Rd=0 followed by a reader with RS1=0 gives Stall_o=0, and EXMEM_RegWrite_o=0 when that load reaches MEM.
REQ-033 SHALL: a load-use condition with Flush_i=1 in the same cycle gives Stall_o=0, and a bubble appears in EX (EXMEM_RegWrite_o=0 two edges later).
REQ-034 SHALL: Freeze_i=1 for 4 cycles with a load in EX and a dependent instruction in ID gives:
- Stall_o=1 throughout the freeze;
- the slots unchanged;
- StallCount_o unchanged;
- after release, StallCount_o +1 and Stall_o drops.
REQ-035 SHALL: asserting rst_i=0 between edges, with MEM holding Rd=9, drops EXMEM_Rd_o to 0 immediately, with no clock edge.
